// File: rtl/serial_arith_pkg.sv
// rtl/serial_arith_pkg.sv - shared state encoding and default width for the serial arithmetic blocks
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_adder_cell.sv
// rtl/full_adder_cell.sv - 1-bit full adder built from two half adders and an OR
module half_adder (
    input  logic i_a,
    input  logic i_b,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_a ^ i_b;
    assign o_c = i_a & i_b;
endmodule

module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic w_s0;
    logic w_c0;
    logic w_c1;

    half_adder u_ha0 (
        .i_a (a),
        .i_b (b),
        .o_s (w_s0),
        .o_c (w_c0)
    );

    half_adder u_ha1 (
        .i_a (w_s0),
        .i_b (cin),
        .o_s (s),
        .o_c (w_c1)
    );

    // Both half-adder carries can never be high together, so OR equals the sum of them.
    assign cout = w_c0 | w_c1;
endmodule

// File: rtl/bit_serial_adder_ctrl.sv
// rtl/bit_serial_adder_ctrl.sv - LSB-first serial adder controller; BIT_SERIAL_SUB_EN adds a subtract mode
module bit_serial_adder_ctrl
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef BIT_SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;

    logic             w_s;
    logic             w_c;
    logic [WIDTH-1:0] w_b_load;
    logic             w_c_load;
    logic [WIDTH-1:0] w_res_next;

`ifdef BIT_SERIAL_SUB_EN
    // Two's-complement subtract: a + ~b + 1; cout=1 then means no borrow.
    assign w_b_load = sub ? ~b : b;
    assign w_c_load = sub ? 1'b1 : cin;
`else
    assign w_b_load = b;
    assign w_c_load = cin;
`endif

    full_adder_cell u_fa (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .cin  (r_carry),
        .s    (w_s),
        .cout (w_c)
    );

    assign w_res_next = {w_s, r_res[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= w_b_load;
                        r_carry <= w_c_load;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_a     <= {1'b0, r_a[WIDTH-1:1]};
                    r_b     <= {1'b0, r_b[WIDTH-1:1]};
                    r_res   <= w_res_next;
                    r_carry <= w_c;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        sum     <= w_res_next;
                        cout    <= w_c;
                        done    <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bit_serial_adder_ctrl.sv
// tb/tb_bit_serial_adder_ctrl.sv - directed self-checking bench for bit_serial_adder_ctrl
module tb_bit_serial_adder_ctrl;

    localparam int WIDTH = 8;
    localparam int BOUND = 40;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             cin = 1'b0;
`ifdef BIT_SERIAL_SUB_EN
    logic             sub = 1'b0;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bit_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef BIT_SERIAL_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycles from now until done is seen high; BOUND+1 when it never comes.
    task automatic wait_done(output int n, output int busy_low);
        n = 0;
        busy_low = 0;
        while (n <= BOUND) begin
            tick();
            n++;
            if (!busy) busy_low++;
            if (done) break;
        end
    endtask

    task automatic count_done(input int cycles, output int seen);
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (done) seen++;
        end
    endtask

    task automatic run_add(input string tag, input logic [7:0] va, input logic [7:0] vb,
                           input logic vc, input logic [7:0] es, input logic ec);
        int n;
        int bl;
        a = va;
        b = vb;
        cin = vc;
        start = 1'b1;
        tick();
        start = 1'b0;
        a = ~va;
        b = ~vb;
        cin = ~vc;
        check({tag, "_busy_after_start"}, 64'(busy), 64'd1);
        wait_done(n, bl);
        check({tag, "_latency"}, 64'(n), 64'd8);
        check({tag, "_busy_while_run"}, 64'(bl), 64'd0);
        check({tag, "_sum"}, 64'(sum), 64'(es));
        check({tag, "_cout"}, 64'(cout), 64'(ec));
        tick();
        check({tag, "_done_one_cycle"}, 64'(done), 64'd0);
        check({tag, "_busy_drop"}, 64'(busy), 64'd0);
        check({tag, "_sum_held"}, 64'(sum), 64'(es));
    endtask

    initial begin
        int n;
        int bl;
        int seen;

        #2;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_sum", 64'(sum), 64'd0);
        check("reset_cout", 64'(cout), 64'd0);
        tick();
        rst = 1'b0;
        tick();

        run_add("t1", 8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0);
        run_add("t2a", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        run_add("t2b", 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0);

        // start during RUN must be dropped
        a = 8'h01;
        b = 8'h01;
        cin = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t3_sum_kept_on_accept", 64'(sum), 64'h80);
        tick();
        tick();
        a = 8'h11;
        b = 8'h22;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(n, bl);
        check("t3_latency", 64'(n + 3), 64'd8);
        check("t3_sum", 64'(sum), 64'h02);
        check("t3_cout", 64'(cout), 64'd0);
        count_done(25, seen);
        check("t3_no_second_done", 64'(seen), 64'd0);
        check("t3_idle", 64'(busy), 64'd0);

        // asynchronous reset in the middle of RUN
        a = 8'h0F;
        b = 8'h0F;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        #2;
        rst = 1'b1;
        #1;
        check("t4_busy_async", 64'(busy), 64'd0);
        check("t4_done_async", 64'(done), 64'd0);
        check("t4_sum_async", 64'(sum), 64'd0);
        check("t4_cout_async", 64'(cout), 64'd0);
        tick();
        rst = 1'b0;
        count_done(20, seen);
        check("t4_no_done_after_reset", 64'(seen), 64'd0);
        run_add("t4_after", 8'h25, 8'h13, 1'b0, 8'h38, 1'b0);

        // start held high: RUN(8) + DONE(1) + IDLE(1) between accepts
        a = 8'h01;
        b = 8'h02;
        cin = 1'b0;
        start = 1'b1;
        tick();
        a = 8'h03;
        b = 8'h04;
        wait_done(n, bl);
        check("t5_first_latency", 64'(n), 64'd8);
        check("t5_first_sum", 64'(sum), 64'h03);
        wait_done(n, bl);
        start = 1'b0;
        check("t5_done_spacing", 64'(n), 64'd10);
        check("t5_second_sum", 64'(sum), 64'h07);
        check("t5_second_cout", 64'(cout), 64'd0);
        count_done(15, seen);

`ifdef BIT_SERIAL_SUB_EN
        sub = 1'b1;
        run_add("t6a", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b1);
        run_add("t6b", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b0);
        sub = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
